ring_phase_monitor: RTL and testbench
=====================================

RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 Parameter WIDTH, default 4, ring width in bits; one-hot input width.
REQ-002 Parameter REV_W, default 8, revolution counter width.
REQ-003 Parameter LOCK_CYCLES, default 4, consecutive correct advances required to lock; legal range 1..15.
REQ-004 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port phase_in  input  WIDTH  one-hot phase from the upstream four-bit ring counter output q.
REQ-007 Port clear  input  1  synchronous clear of FSM and counters, active-high.
REQ-008 Port phase_idx  output  $clog2(WIDTH)  binary index of the current one-hot bit.
REQ-009 Port phase_valid  output  1  current sample is exactly one-hot.
REQ-010 Port locked  output  1  high while FSM is in LOCKED.
REQ-011 Port rev_tick  output  1  one-cycle pulse per completed revolution while locked.
REQ-012 Port rev_count  output  REV_W  completed revolutions since lock, reset or clear.
REQ-013 Port seq_err  output  1  one-cycle pulse on a sequence violation while LOCKED.
REQ-014 Port err_count  output  8  saturating count of seq_err pulses; present only under RING_MON_ERRCNT_EN.

Function
REQ-015 phase_in SHALL be registered into sample s0 every cycle, and s0 copied into prev s1 every cycle.
REQ-016 Expected next value SHALL be a left rotate of s1: {s1[WIDTH-2:0], s1[WIDTH-1]}.
REQ-017 All outputs SHALL be registered; phase_in presented before edge k SHALL be reflected on phase_idx/phase_valid after edge k+1 (2-cycle latency).
REQ-018 For a non-one-hot s0 (zero or multi-hot), phase_valid SHALL be 0 and phase_idx SHALL be 0.
REQ-019 FSM states SHALL be HUNT, LOCKING, LOCKED; the reset state is HUNT.
REQ-020 HUNT: a one-hot s0 -> LOCKING with good count 1; otherwise stay in HUNT.
REQ-021 LOCKING: s0 == expected -> increment good count; reaching LOCK_CYCLES -> LOCKED, with rev_count cleared on entry.
REQ-022 LOCKING mismatch: a one-hot s0 restarts the good count at 1; a non-one-hot s0 -> HUNT; no seq_err in either case.
REQ-023 LOCKED: s0 != expected (including a repeated value, zero, or multi-hot) -> seq_err pulse for 1 cycle and transition to HUNT.
REQ-024 LOCKED with s1[WIDTH-1]=1 and s0[0]=1 (wrap) -> rev_tick pulse for 1 cycle and rev_count+1.
REQ-025 rev_count SHALL wrap from 2^REV_W-1 to 0; rev_tick still pulses on the wrap.
REQ-026 clear SHALL take priority over every transition: state HUNT, counters 0, and no rev_tick/seq_err that cycle; s0/s1 keep sampling.
REQ-027 Error and wrap in the same cycle is impossible by construction; the error path SHALL win if the expected-value logic is ever violated.

Reset
REQ-028 reset low SHALL immediately force state HUNT, s0=s1=0, good count 0, and phase_idx, phase_valid, locked, rev_tick, rev_count, seq_err, err_count all 0.
REQ-029 Reset asserted mid-revolution SHALL discard the lock; reacquisition requires LOCK_CYCLES fresh correct advances after release.

Configuration
REQ-030 Macro RING_MON_ERRCNT_EN defined: the err_count port and an 8-bit counter exist; the counter increments per seq_err, saturates at 255, and clears on reset/clear.
REQ-031 RING_MON_ERRCNT_EN undefined: no err_count port and no counter logic; all other behaviour is identical.

Structure
REQ-032 Shared package ring_pkg SHALL hold the FSM state typedef (HUNT/LOCKING/LOCKED) and the default WIDTH/REV_W/LOCK_CYCLES constants.
REQ-033 One-hot validity check and index encoding SHALL live in sub-module ring_onehot_enc (inputs onehot; outputs idx, valid).

Verification
REQ-034 Reset released with phase_in cycling 0001->0010->0100->1000 each clock -> locked=1 after 2+4 edges; phase_idx follows 0,1,2,3 with 2-cycle lag.
REQ-035 Locked, run 3 full revolutions -> 3 rev_tick pulses, rev_count=3, seq_err=0.
REQ-036 Locked, force phase_in=0110 for one cycle -> seq_err pulse, phase_valid=0, locked=0; err_count=1 with the macro.
REQ-037 Locked, hold phase_in=0100 for two cycles -> seq_err pulse, FSM returns to HUNT, relock after 4 good advances.
REQ-038 REV_W=2, locked, 5 revolutions -> rev_count sequence 1,2,3,0,1 with a rev_tick on each.
REQ-039 clear asserted on the same cycle as a wrap -> rev_count=0, no rev_tick, locked=0; reset mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and default sizing for the ring phase monitor.
package ring_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_REV_W       = 8;
    localparam int DEF_LOCK_CYCLES = 4;

    // Good-advance counter width; wide enough for the largest legal LOCK_CYCLES (15).
    localparam int GOOD_W = 4;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } ring_state_t;

endpackage

// File: rtl/ring_onehot_enc.sv
// One-hot validity check and binary index encoder; idx is 0 whenever the input is not exactly one-hot.
module ring_onehot_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         onehot,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] idx_terms [WIDTH];

    // Zero or multi-hot both fail: a one-hot value has exactly one bit and x & (x-1) clears it.
    assign valid = (onehot != '0) && ((onehot & (onehot - WIDTH'(1))) == '0);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_term
            assign idx_terms[gi] = onehot[gi] ? IDX_W'(gi) : '0;
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = idx | idx_terms[i];
        end
        if (!valid) begin
            idx = '0;
        end
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// Monitors a one-hot ring counter: locks onto correct left-rotating advances, counts revolutions, flags breaks.
// Optional RING_MON_ERRCNT_EN adds the saturating err_count port and counter.
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int REV_W       = DEF_REV_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         phase_in,
    input  logic                     clear,
    output logic [$clog2(WIDTH)-1:0] phase_idx,
    output logic                     phase_valid,
    output logic                     locked,
    output logic                     rev_tick,
    output logic [REV_W-1:0]         rev_count,
    output logic                     seq_err
`ifdef RING_MON_ERRCNT_EN
    ,
    output logic [7:0]               err_count
`endif
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_CYCLES);

    ring_state_t       state_reg;
    logic [GOOD_W-1:0] good_reg;
    logic [WIDTH-1:0]  s0_reg;
    logic [WIDTH-1:0]  s1_reg;

    logic [WIDTH-1:0]  expected;
    logic [IDX_W-1:0]  s0_idx;
    logic              s0_valid;
    logic              match;
    logic              wrap;
    logic              err_event;
    logic              tick_event;

    ring_onehot_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .onehot (s0_reg),
        .idx    (s0_idx),
        .valid  (s0_valid)
    );

    assign expected = {s1_reg[WIDTH-2:0], s1_reg[WIDTH-1]};
    assign match    = s0_valid && (s0_reg == expected);
    assign wrap     = s1_reg[WIDTH-1] & s0_reg[0];

    // Error is tested on mismatch alone so it always beats a coincident wrap.
    assign err_event  = !clear && (state_reg == LOCKED) && !match;
    assign tick_event = !clear && (state_reg == LOCKED) && match && wrap;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= HUNT;
            good_reg    <= '0;
            s0_reg      <= '0;
            s1_reg      <= '0;
            phase_idx   <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            rev_tick    <= 1'b0;
            rev_count   <= '0;
            seq_err     <= 1'b0;
        end else begin
            s0_reg      <= phase_in;
            s1_reg      <= s0_reg;
            phase_idx   <= s0_idx;
            phase_valid <= s0_valid;
            rev_tick    <= tick_event;
            seq_err     <= err_event;

            if (clear) begin
                state_reg <= HUNT;
                good_reg  <= '0;
                rev_count <= '0;
                locked    <= 1'b0;
            end else begin
                case (state_reg)
                    HUNT: begin
                        if (s0_valid) begin
                            state_reg <= LOCKING;
                            good_reg  <= GOOD_W'(1);
                        end
                    end
                    LOCKING: begin
                        if (match) begin
                            if (good_reg >= LOCK_TARGET) begin
                                state_reg <= LOCKED;
                                locked    <= 1'b1;
                                rev_count <= '0;
                                good_reg  <= '0;
                            end else begin
                                good_reg <= good_reg + GOOD_W'(1);
                            end
                        end else if (s0_valid) begin
                            good_reg <= GOOD_W'(1);
                        end else begin
                            state_reg <= HUNT;
                            good_reg  <= '0;
                        end
                    end
                    LOCKED: begin
                        if (err_event) begin
                            state_reg <= HUNT;
                            locked    <= 1'b0;
                            good_reg  <= '0;
                        end else if (tick_event) begin
                            rev_count <= rev_count + REV_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= HUNT;
                        locked    <= 1'b0;
                        good_reg  <= '0;
                    end
                endcase
            end
        end
    end

`ifdef RING_MON_ERRCNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (err_event && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor: lock, revolutions, sequence errors, clear and async reset.
module tb_ring_phase_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] phase_in;
    logic       clear;

    logic [1:0] phase_idx, phase_idx2;
    logic       phase_valid, phase_valid2;
    logic       locked, locked2;
    logic       rev_tick, rev_tick2;
    logic [7:0] rev_count;
    logic [1:0] rev_count2;
    logic       seq_err, seq_err2;
`ifdef RING_MON_ERRCNT_EN
    logic [7:0] err_count, err_count2;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int e            = 0;

    int exp_rev1 [5] = '{1, 2, 3, 4, 5};
    int exp_rev2 [5] = '{1, 2, 3, 0, 1};

    always #5 clock = ~clock;

    ring_phase_monitor #(.WIDTH(4), .REV_W(8), .LOCK_CYCLES(4)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .phase_in    (phase_in),
        .clear       (clear),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .locked      (locked),
        .rev_tick    (rev_tick),
        .rev_count   (rev_count),
        .seq_err     (seq_err)
`ifdef RING_MON_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    ring_phase_monitor #(.WIDTH(4), .REV_W(2), .LOCK_CYCLES(4)) u_dut2 (
        .clock       (clock),
        .reset       (reset),
        .phase_in    (phase_in),
        .clear       (clear),
        .phase_idx   (phase_idx2),
        .phase_valid (phase_valid2),
        .locked      (locked2),
        .rev_tick    (rev_tick2),
        .rev_count   (rev_count2),
        .seq_err     (seq_err2)
`ifdef RING_MON_ERRCNT_EN
        ,
        .err_count   (err_count2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s (edge %0d): got %0d, expected %0d", tag, e, got, exp);
        end else begin
            $display("[TB] ok   %s (edge %0d) = %0d", tag, e, got);
        end
    endtask

    function automatic logic [3:0] ring(input int n);
        logic [3:0] one;
        one = 4'b0001;
        return one << (n % 4);
    endfunction

    task automatic step(input logic [3:0] p, input logic c);
        phase_in = p;
        clear    = c;
        @(posedge clock);
        #1;
        e++;
    endtask

    task automatic ring_step();
        step(ring(e), 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        phase_in = 4'b0000;
        clear    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_locked", locked, 0);
        check("rst_valid", phase_valid, 0);
        check("rst_idx", phase_idx, 0);
        check("rst_rev_count", rev_count, 0);
        check("rst_tick", rev_tick, 0);
        check("rst_seq_err", seq_err, 0);
`ifdef RING_MON_ERRCNT_EN
        check("rst_err_count", err_count, 0);
`endif
        reset = 1'b1;

        // Acquisition: two pipeline edges then four correct advances.
        ring_step(); check("e1_valid", phase_valid, 0);
        ring_step(); check("e2_valid", phase_valid, 1); check("e2_idx", phase_idx, 0); check("e2_locked", locked, 0);
        ring_step(); check("e3_idx", phase_idx, 1);
        ring_step(); check("e4_idx", phase_idx, 2);
        ring_step(); check("e5_idx", phase_idx, 3); check("e5_locked", locked, 0);
        ring_step(); check("e6_locked", locked, 1); check("e6_rev_count", rev_count, 0); check("e6_tick", rev_tick, 0);

        // Five revolutions; the narrow instance wraps its count.
        for (int k = 7; k <= 26; k++) begin
            ring_step();
            check("rev_tick", rev_tick, (e % 4 == 2) ? 1 : 0);
            check("rev_seq_err", seq_err, 0);
            if (e % 4 == 2) begin
                check("rev_count", rev_count, exp_rev1[(e - 10) / 4]);
                check("rev_count_w2", rev_count2, exp_rev2[(e - 10) / 4]);
                check("rev_tick_w2", rev_tick2, 1);
            end
        end

        // Multi-hot glitch while locked.
        step(4'b0110, 1'b0); check("mh_seq_err_pre", seq_err, 0);
        ring_step();
        check("mh_seq_err", seq_err, 1); check("mh_locked", locked, 0); check("mh_valid", phase_valid, 0);
`ifdef RING_MON_ERRCNT_EN
        check("mh_err_count", err_count, 1);
`endif
        ring_step(); check("mh_seq_err_pulse", seq_err, 0);
        ring_step(); ring_step(); ring_step(); check("mh_relock_e32", locked, 0);
        ring_step(); check("mh_relock_e33", locked, 1); check("mh_relock_rev", rev_count, 0);
        ring_step(); check("e34_tick", rev_tick, 1); check("e34_rev_count", rev_count, 1);

        // Repeated phase (stall) while locked.
        ring_step();
        step(4'b0100, 1'b0); check("st_seq_err_pre", seq_err, 0); check("st_locked_pre", locked, 1);
        ring_step();
        check("st_seq_err", seq_err, 1); check("st_locked", locked, 0);
`ifdef RING_MON_ERRCNT_EN
        check("st_err_count", err_count, 2);
`endif
        ring_step(); check("st_seq_err_pulse", seq_err, 0);
        ring_step(); ring_step(); ring_step(); check("st_relock_e41", locked, 0);
        ring_step(); check("st_relock_e42", locked, 1);

        // Clear on a wrap cycle.
        for (int k = 43; k <= 53; k++) ring_step();
        check("pre_clr_rev_count", rev_count, 2); check("pre_clr_locked", locked, 1);
        step(ring(e), 1'b1);
        check("clr_rev_count", rev_count, 0); check("clr_tick", rev_tick, 0); check("clr_locked", locked, 0);
        check("clr_rev_count_w2", rev_count2, 0); check("clr_valid", phase_valid, 1);
`ifdef RING_MON_ERRCNT_EN
        check("clr_err_count", err_count, 0);
`endif
        ring_step(); ring_step(); ring_step(); ring_step(); check("clr_relock_e58", locked, 0);
        ring_step(); check("clr_relock_e59", locked, 1);
        ring_step(); ring_step(); ring_step(); check("e62_tick", rev_tick, 1);
        ring_step();
        check("e63_locked", locked, 1); check("e63_rev_count", rev_count, 1); check("e63_idx", phase_idx, 1);

        // Asynchronous reset mid-run, then fresh reacquisition.
        reset = 1'b0;
        #2;
        check("arst_locked", locked, 0); check("arst_valid", phase_valid, 0); check("arst_idx", phase_idx, 0);
        check("arst_rev_count", rev_count, 0); check("arst_tick", rev_tick, 0); check("arst_seq_err", seq_err, 0);
        reset = 1'b1;
        for (int k = 64; k <= 68; k++) ring_step();
        check("arst_relock_e68", locked, 0);
        ring_step(); check("arst_relock_e69", locked, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
